// File: rtl/axi_write_dispatcher.sv
// axi_write_dispatcher
// Drains queued write requests from an address FIFO and a write-data FIFO onto
// the AXI AW/W channels, collects the B response into a response FIFO, and
// keeps a saturating count of SLVERR/DECERR responses. One transaction at a time.
//
// Ports
//   clk, clr        clock (rising edge) / asynchronous active-low reset
//   aw_head         address FIFO head {len[7:0], addr}; aw_empty, aw_rd_en (pop)
//   w_head          data FIFO head {strb, data}; w_empty, w_rd_en (pop)
//   aw*             AXI write address channel (awaddr/awlen/awvalid registered)
//   w*              AXI write data channel (combinational from the data FIFO head)
//   bresp/bvalid    AXI write response; bready combinational
//   resp_wr_en      response FIFO push with resp_data = bresp; resp_full backpressure
//   busy            high whenever a transaction is in flight
//   err_count       saturating count of responses with bresp[1] set
module axi_write_dispatcher #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                clr,
  input  logic [8+ADDR_WIDTH-1:0]             aw_head,
  input  logic                                aw_empty,
  output logic                                aw_rd_en,
  input  logic [DATA_WIDTH/8+DATA_WIDTH-1:0]  w_head,
  input  logic                                w_empty,
  output logic                                w_rd_en,
  output logic [ADDR_WIDTH-1:0]               awaddr,
  output logic [7:0]                          awlen,
  output logic                                awvalid,
  input  logic                                awready,
  output logic [DATA_WIDTH-1:0]               wdata,
  output logic [DATA_WIDTH/8-1:0]             wstrb,
  output logic                                wlast,
  output logic                                wvalid,
  input  logic                                wready,
  input  logic [1:0]                          bresp,
  input  logic                                bvalid,
  output logic                                bready,
  output logic                                resp_wr_en,
  output logic [1:0]                          resp_data,
  input  logic                                resp_full,
  output logic                                busy,
  output logic [15:0]                         err_count
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LEN_WIDTH  = 8;
  localparam int unsigned CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [LEN_WIDTH-1:0]   awlen_q, awlen_d;
  logic                   awvalid_q, awvalid_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;

  // Next-state and combinational channel/FIFO controls.
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    awvalid_d   = awvalid_q;
    beat_d      = beat_q;
    err_count_d = err_count_q;
    aw_rd_en    = 1'b0;
    w_rd_en     = 1'b0;
    wvalid      = 1'b0;
    wdata       = '0;
    wstrb       = '0;
    wlast       = 1'b0;
    bready      = 1'b0;
    resp_wr_en  = 1'b0;
    resp_data   = '0;

    case (state_q)
      S_IDLE: begin
        if (!aw_empty) begin
          aw_rd_en  = 1'b1;
          awaddr_d  = aw_head[ADDR_WIDTH-1:0];
          awlen_d   = aw_head[ADDR_WIDTH +: LEN_WIDTH];
          awvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end

      S_ADDR: begin
        if (awready) begin
          awvalid_d = 1'b0;
          beat_d    = '0;
          state_d   = S_DATA;
        end
      end

      // Only this block pops the data FIFO, so wvalid can only fall after a handshake.
      S_DATA: begin
        wvalid  = !w_empty;
        wdata   = w_head[DATA_WIDTH-1:0];
        wstrb   = w_head[DATA_WIDTH +: STRB_WIDTH];
        wlast   = (beat_q == awlen_q);
        w_rd_en = !w_empty && wready;
        if (!w_empty && wready) begin
          if (beat_q == awlen_q) begin
            state_d = S_RESP;
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end

      S_RESP: begin
        bready = !resp_full;
        if (bvalid && !resp_full) begin
          resp_wr_en = 1'b1;
          resp_data  = bresp;
          // SLVERR and DECERR both have bresp[1] set; the counter sticks at all-ones.
          if (bresp[1] && (err_count_q != {CNT_WIDTH{1'b1}})) begin
            err_count_d = err_count_q + CNT_WIDTH'(1);
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      beat_q      <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awvalid_q   <= awvalid_d;
      beat_q      <= beat_d;
      err_count_q <= err_count_d;
    end
  end

  assign awaddr    = awaddr_q;
  assign awlen     = awlen_q;
  assign awvalid   = awvalid_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != S_IDLE);

endmodule
